// File: rtl/elastic_pkg.sv
// elastic_pkg: shared sizing helpers for the elastic join/add stage
package elastic_pkg;
  function automatic int occ_w(input int depth);
    return $clog2(depth) + 1;
  endfunction
  localparam int DEPTH_DEF = 2;
  localparam int OCC_W = occ_w(DEPTH_DEF);
endpackage

// File: rtl/elastic_fifo.sv
// elastic_fifo: DEPTH-entry FIFO with registered head (clock, reset, push, ready -> din in, dout/valid/occupancy out)
module elastic_fifo
  import elastic_pkg::*;
#(
  parameter int W = 33,
  parameter int DEPTH = 2
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     ready,
  input  logic [W-1:0]             din,
  output logic [W-1:0]             dout,
  output logic                     valid,
  output logic [occ_w(DEPTH)-1:0]  occupancy
);
  localparam int AW = $clog2(DEPTH);
  localparam int OW = occ_w(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic pop;
  assign valid = occupancy != '0;
  assign pop = valid & ready;
  always_ff @(posedge clock)
    if (push) mem[wptr] <= din;
  always_ff @(posedge clock) begin
    if (reset) begin
      wptr <= '0;
      rptr <= '0;
      occupancy <= '0;
      dout <= '0;
    end else begin
      if (push) wptr <= wptr + AW'(1);
      if (pop) rptr <= rptr + AW'(1);
      occupancy <= occupancy + OW'(push) - OW'(pop);
      if (push && (occupancy == '0 || (pop && occupancy == OW'(1))))
        dout <= din;
      else if (pop && occupancy > OW'(1))
        dout <= mem[rptr + AW'(1)];
    end
  end
endmodule

// File: rtl/elastic_join_add_n.sv
// elastic_join_add_n: joins NUM_IN valid/ready channels, adds operands + INCR, buffers sum/carry (in_data/in_valid/in_ready -> out_data/out_carry/out_valid/out_ready, occupancy)
module elastic_join_add_n
  import elastic_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int NUM_IN = 2,
  parameter logic [WIDTH-1:0] INCR = '0,
  parameter int DEPTH = 2
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [NUM_IN*WIDTH-1:0]  in_data,
  input  logic [NUM_IN-1:0]        in_valid,
  output logic [NUM_IN-1:0]        in_ready,
  output logic [WIDTH-1:0]         out_data,
  output logic                     out_carry,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [occ_w(DEPTH)-1:0]  occupancy
);
  localparam int SW = WIDTH + $clog2(NUM_IN + 1);
  typedef struct packed {
    logic carry;
    logic [WIDTH-1:0] data;
  } entry_t;
  logic [SW-1:0] full;
  logic push;
  entry_t din, head;
  always_comb begin
    full = SW'(INCR);
    for (int i = 0; i < NUM_IN; i++) full = full + SW'(in_data[i*WIDTH +: WIDTH]);
  end
  assign din = '{carry: |full[SW-1:WIDTH], data: full[WIDTH-1:0]};
  assign push = &in_valid & (occupancy != occ_w(DEPTH)'(DEPTH)) & ~reset;
  assign in_ready = {NUM_IN{push}};
  elastic_fifo #(.W($bits(entry_t)), .DEPTH(DEPTH)) u_fifo (
    .clock(clock),
    .reset(reset),
    .push(push),
    .ready(out_ready),
    .din(din),
    .dout(head),
    .valid(out_valid),
    .occupancy(occupancy)
  );
  assign out_data = head.data;
  assign out_carry = head.carry;
endmodule
